// File: rtl/cla_divider_seq.sv
// Iterative 32-bit unsigned restoring divider that time-shares one external cla adder, one quotient bit per cycle.
// Optional feature macro: CLA_DIV_DBZ_FLAG_EN (adds div_by_zero port and a one-cycle divide-by-zero path).
module cla_divider_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum
`ifdef CLA_DIV_DBZ_FLAG_EN
  ,
  output logic             div_by_zero
`endif
);

  if (WIDTH != 32) begin : g_width_chk
    $error("cla_divider_seq: WIDTH must be 32 to match the cla adder");
  end

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dreg_q, dreg_d;
`ifdef CLA_DIV_DBZ_FLAG_EN
  logic               dbz_q, dbz_d;
`endif

  // Partial remainder shifted left by one; rem_q[WIDTH-1] is its implicit 33rd bit.
  logic [WIDTH-1:0]   shifted;
  logic               cout;
  logic               take;
  logic               accept;

  assign shifted = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
  assign accept  = in_valid & in_ready;

  // NOTE: every signal written here gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dreg_d  = dreg_q;
`ifdef CLA_DIV_DBZ_FLAG_EN
    dbz_d   = dbz_q;
`endif
    in_ready = (state_q == IDLE) & ~rst;
    add_a    = '0;
    add_b    = '0;
    add_cin  = 1'b0;
    cout     = 1'b0;
    take     = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          quo_d   = dividend;
          rem_d   = '0;
          dreg_d  = divisor;
          count_d = '0;
          state_d = RUN;
`ifdef CLA_DIV_DBZ_FLAG_EN
          dbz_d   = 1'b0;
          if (divisor == '0) begin
            quo_d   = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end
`endif
        end
      end

      RUN: begin
        // Trial subtraction shifted - divisor as shifted + ~divisor + 1 on the shared adder.
        add_a   = shifted;
        add_b   = ~dreg_q;
        add_cin = 1'b1;
        cout    = (add_a[WIDTH-1] & add_b[WIDTH-1]) |
                  ((add_a[WIDTH-1] ^ add_b[WIDTH-1]) & ~add_sum[WIDTH-1]);
        take    = rem_q[WIDTH-1] | cout;
        rem_d   = take ? add_sum : shifted;
        quo_d   = {quo_q[WIDTH-2:0], take};
        count_d = count_q + CNT_W'(1);
        if (count_q == '1) begin
          state_d = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dreg_q  <= '0;
`ifdef CLA_DIV_DBZ_FLAG_EN
      dbz_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dreg_q  <= dreg_d;
`ifdef CLA_DIV_DBZ_FLAG_EN
      dbz_q   <= dbz_d;
`endif
    end
  end

  // Results are gated so they only show while out_valid is high.
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign quotient  = out_valid ? quo_q : '0;
  assign remainder = out_valid ? rem_q : '0;
`ifdef CLA_DIV_DBZ_FLAG_EN
  assign div_by_zero = out_valid & dbz_q;
`endif

endmodule
